// File: rtl/ginv_pipe.sv
// ---------------------------------------------------------------------------
// ginv_pipe
//
// Pipelined, parametrised word inverter. Each accepted word is transformed
// once, as it enters stage 0, and then travels through STAGES valid/ready
// register stages to the consumer. Empty stages always take a word from
// upstream, so bubbles collapse even while the output is stalled.
//
// Transforms (selected by mode when the word is accepted):
//   00 pass, 01 invert all bits, 10 xor with the mask register,
//   11 invert when the accept parity flop is 0, else pass.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake, in_data is the word
//   mode                  transform select, captured on accept
//   mask_we/mask_in       load a new mask; an accept in the same cycle
//                         still sees the old mask
//   out_valid/out_ready   downstream handshake, out_data is the word
//   count                 completed output handshakes, modulo 2^16
// ---------------------------------------------------------------------------
module ginv_pipe #(
    parameter int               WIDTH    = 8,
    parameter int               STAGES   = 2,
    parameter logic [WIDTH-1:0] MASK_RST = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       mode,
    input  logic             mask_we,
    input  logic [WIDTH-1:0] mask_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      count
);

    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [STAGES-1:0] stage_ready;
    logic              up_valid [STAGES];
    logic [WIDTH-1:0]  up_data  [STAGES];
    logic [WIDTH-1:0]  mask_q;
    logic              parity_q;
    logic [15:0]       count_q;
    logic [WIDTH-1:0]  xform_data;
    logic              accept;
    logic              out_fire;

    // Ready ripples back from the consumer: a stage can take a word when it
    // is empty or when the stage after it is itself able to move.
    always_comb begin
        logic r;
        r = out_ready;
        stage_ready = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            r = ~valid_q[i] | r;
            stage_ready[i] = r;
        end
    end

    assign in_ready  = stage_ready[0];
    assign accept    = in_valid & stage_ready[0];
    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_fire  = valid_q[STAGES-1] & out_ready;
    assign count     = count_q;

    // Transform uses the mask and parity as they stand before this edge.
    always_comb begin
        xform_data = in_data;
        case (mode)
            2'b00:   xform_data = in_data;
            2'b01:   xform_data = ~in_data;
            2'b10:   xform_data = in_data ^ mask_q;
            default: xform_data = parity_q ? in_data : ~in_data;
        endcase
    end

    // What each stage would load: stage 0 takes the freshly transformed
    // word, later stages take the contents of their predecessor.
    always_comb begin
        up_valid[0] = accept;
        up_data[0]  = xform_data;
        for (int i = 1; i < STAGES; i++) begin
            up_valid[i] = valid_q[i-1];
            up_data[i]  = data_q[i-1];
        end
    end

    // Stage registers. Data only loads alongside a valid word so a drained
    // stage keeps its last contents instead of picking up junk.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (stage_ready[i]) begin
                    valid_q[i] <= up_valid[i];
                    if (up_valid[i]) begin
                        data_q[i] <= up_data[i];
                    end
                end
            end
        end
    end

    // Mask register, accept parity and output handshake counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q   <= MASK_RST;
            parity_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (mask_we) begin
                mask_q <= mask_in;
            end
            if (accept) begin
                parity_q <= ~parity_q;
            end
            if (out_fire) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

endmodule

// File: doc/ginv_pipe.md
# ginv_pipe

Parametrised, pipelined successor to the single-bit combinational inverter. It applies a selectable inversion transform to a WIDTH-bit word: pass, invert all bits, invert masked bits, or invert alternate words. Words move through a STAGES-deep valid/ready pipeline with a programmable mask register and an output word counter. It sits between a word producer and consumer on the same clock domain, for example a polarity-correction stage on a parallel data bus.

## Interface
- WIDTH, 8: data width in bits, at least 1.
- STAGES, 2: number of pipeline register stages, at least 1.
- MASK_RST, {WIDTH{1'b1}}: reset value of the mask register.

- clk  in  1  clock; all logic is on its rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input word is valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WIDTH  input word.
- mode  in  2  transform select, sampled on accept: 00 pass, 01 invert all, 10 xor mask, 11 alternate.
- mask_we  in  1  load mask_in into the mask register.
- mask_in  in  WIDTH  new mask value.
- out_valid  out  1  output word is valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  WIDTH  transformed word.
- count  out  16  number of completed output handshakes, modulo 2^16.

## Operation
- Accept: in_valid & in_ready. Output handshake: out_valid & out_ready.
- The transform is applied when a word enters stage 0, using mode, mask and parity as they stand in that cycle:
  - 00: d.
  - 01: ~d.
  - 10: d ^ mask.
  - 11: ~d if parity==0, else d.
- Parity is a 1-bit flop that toggles on every accept, in every mode.
- Each stage i holds data_i and valid_i. Stage i advances when ready_i = ~valid_i | ready_(i+1); ready_STAGES = out_ready.
  - in_ready = ready_0.
  - out_valid = valid_(STAGES-1); out_data = data_(STAGES-1).
- Bubbles collapse: an empty stage always accepts from upstream, even while the output is stalled.
- Mask register: loads mask_in when mask_we=1. If mask_we and an accept occur in the same cycle, the accepted word uses the old mask; the new mask applies from the next cycle.
- count increments by 1 on each output handshake and wraps from 0xFFFF to 0x0000.
- Data and mode are held per word in flight. Changing mode or mask never alters words already accepted.
- No word is dropped or duplicated. Output order equals accept order.

## Timing
- Reset, in any state or mid-transfer, takes effect at the next rising edge. After that edge:
  - all valid_i=0, all data_i=0, so out_valid=0 and out_data=0.
  - mask=MASK_RST, parity=0, count=0.
  - in_ready=1 in the cycle after reset deasserts.
- In-flight words are discarded by reset and are not counted.
- Latency: a word accepted at edge N appears on out_valid after edge N+STAGES-1, so it is visible for handshake in the cycle following that edge. With STAGES=1 it is visible in the cycle after the accept.
- Throughput is one word per cycle while out_ready=1 continuously.
- While out_valid=1 and out_ready=0, out_data and out_valid are held stable.
- Full condition: all stages valid and out_ready=0 gives in_ready=0.
- in_ready depends combinationally on out_ready. There is no other combinational path from input to output.
- Simultaneous output handshake and accept on a full pipeline: both complete, and occupancy is unchanged.

## Test plan
- Reset/idle (WIDTH=8, STAGES=2): assert rst for 2 cycles. Expect out_valid=0, out_data=0x00, count=0, in_ready=1, and mask=0xFF (verified via mode 10 on 0x0F giving 0xF0).
- Streaming: send 0x00, 0x5A, 0xFF in mode 01 on consecutive cycles with out_ready=1. Expect 0xFF, 0xA5, 0x00 on consecutive cycles, each appearing STAGES cycles after its accept; count=3.
- Mask and same-cycle write: mode 10, mask 0xFF. In one cycle, load mask 0x0F while accepting 0x33; next cycle accept 0x33 again. Expect 0xCC (old mask) then 0x3C (new mask).
- Alternate mode: from reset, send 0x01, 0x01, 0x01, 0x01 in mode 11. Expect 0xFE, 0x01, 0xFE, 0x01.
- Backpressure: hold out_ready=0 and offer 4 words. Expect exactly STAGES accepts, then in_ready=0, with out_data stable. Release out_ready and expect all words in order with none lost or duplicated.
- Wrap and reset mid-flight: preload traffic so count reaches 0xFFFF; one more output handshake gives count=0x0000. Assert rst with 2 words in flight and expect out_valid=0 the next cycle and count unchanged by the discarded words, i.e. 0.
